mch_dec_s2p_top: RTL and testbench

Manchester receive path: oversamples the serial line with the system clock, recovers bit timing from mid-bit transitions, and decodes one frame of NBYTES bytes. Each byte is delivered on a parallel output with its index. It is the receive-side counterpart of the encoder/P2S transmit top and uses the same frame layout: byte index on `d_sel` (0 = length, then data), 8 bits per byte MSB first, idle line high.

---
 rtl/mch_dec_s2p_top.sv | 220 ++++++++++++++++++++++
 tb/tb_mch_dec_s2p_top.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mch_dec_s2p_top.sv
// -----------------------------------------------------------------------------
// mch_dec_s2p_top
// Manchester receive path. The serial line is oversampled with the system
// clock. Bit timing is recovered from mid-bit transitions, and one frame of
// NBYTES bytes is decoded and delivered byte by byte on a parallel port.
//
// Frame layout: one start bit (0), then NBYTES x 8 data bits, MSB first,
// byte 0 first. The line idles high.
// Coding: bit 1 = high then low; bit 0 = low then high.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   rxsdi    in   Manchester serial input (asynchronous to clk)
//   p_data   out  [7:0] last completed byte, held until the next one
//   d_sel    out  [2:0] index of the byte on p_data
//   p_valid  out  one-clock pulse when p_data/d_sel update
//   s2p_end  out  one-clock pulse with the last byte of a frame
//   err      out  one-clock pulse on a code violation (frame aborted)
// -----------------------------------------------------------------------------
module mch_dec_s2p_top #(
  parameter int HALF      = 25,  // system clocks per half bit cell, >= 4
  parameter int NBYTES    = 7,   // bytes per frame, 1..8
  parameter int IDLE_BITS = 2    // bit times of high line needed to arm
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxsdi,
  output logic [7:0] p_data,
  output logic [2:0] d_sel,
  output logic       p_valid,
  output logic       s2p_end,
  output logic       err
);

  localparam int CELL     = 2 * HALF;
  localparam int S1_AT    = HALF / 2;
  localparam int S2_AT    = HALF + HALF / 2;
  localparam int IDLE_LIM = IDLE_BITS * CELL;
  localparam int CW       = $clog2(CELL);
  localparam int IW       = $clog2(IDLE_LIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE,   // qualifying a long enough high line
    ST_ARMED,  // waiting for the falling edge of a start bit
    ST_START,  // inside the start bit cell
    ST_DATA    // receiving data bits
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge-detect register
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       line_prev_q;
  logic       line;
  logic       line_edge;
  logic       line_fall;

  // NOTE: the synchronizer resets to the idle (high) level, not 0, so that
  // leaving reset does not fake a falling edge into the decoder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, which is what makes the shift chain a chain.
      sync_q      <= {sync_q[0], rxsdi};
      line_prev_q <= sync_q[1];
    end
  end

  assign line      = sync_q[1];
  assign line_edge = line ^ line_prev_q;
  assign line_fall = line_prev_q & ~line;

  // ---------------------------------------------------------------------------
  // Decoder state
  // ---------------------------------------------------------------------------
  state_t          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [IW-1:0]   idle_q,    idle_d;
  logic            s1_q,      s1_d;
  logic [7:0]      shift_q,   shift_d;
  logic [2:0]      bit_q,     bit_d;
  logic [2:0]      byte_q,    byte_d;
  logic [7:0]      p_data_q,  p_data_d;
  logic [2:0]      d_sel_q,   d_sel_d;
  logic            p_valid_q, p_valid_d;
  logic            s2p_end_q, s2p_end_d;
  logic            err_q,     err_d;

  logic          at_s1, at_s2, at_end, in_win;
  logic [CW-1:0] cnt_run;

  assign at_s1  = (cnt_q == CW'(S1_AT));
  assign at_s2  = (cnt_q == CW'(S2_AT));
  assign at_end = (cnt_q == CW'(CELL - 1));
  assign in_win = (cnt_q > CW'(S1_AT)) && (cnt_q < CW'(S2_AT));

  // Free-running cell counter with mid-bit resync: an edge inside the window
  // around mid-cell is taken as the mid-bit transition and re-centres the cell.
  always_comb begin
    if (line_edge && in_win) cnt_run = CW'(HALF);
    else if (at_end)         cnt_run = '0;
    else                     cnt_run = cnt_q + 1'b1;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_run;
    idle_d    = '0;
    s1_d      = s1_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    p_data_d  = p_data_q;
    d_sel_d   = d_sel_q;
    p_valid_d = 1'b0;
    s2p_end_d = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!line) begin
          idle_d = '0;
        end else if (idle_q == IW'(IDLE_LIM - 1)) begin
          state_d = ST_ARMED;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      ST_ARMED: begin
        cnt_d = '0;
        if (line_fall) state_d = ST_START;
      end

      ST_START: begin
        if (at_s1 && line) begin
          // Too short to be a start bit: treat as a glitch, stay armed.
          state_d = ST_ARMED;
        end else if (at_s2 && !line) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (at_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          byte_d  = '0;
        end
      end

      ST_DATA: begin
        if (at_s1) s1_d = line;
        if (at_s2) begin
          if (line == s1_q) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            shift_d = {shift_q[6:0], s1_q};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              p_data_d  = shift_d;
              d_sel_d   = byte_q;
              p_valid_d = 1'b1;
              if (byte_q == 3'(NBYTES - 1)) begin
                s2p_end_d = 1'b1;
                state_d   = ST_IDLE;
              end else begin
                byte_d = byte_q + 3'd1;
              end
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idle_q    <= '0;
      s1_q      <= 1'b0;
      shift_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      p_data_q  <= '0;
      d_sel_q   <= '0;
      p_valid_q <= 1'b0;
      s2p_end_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      s1_q      <= s1_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      p_data_q  <= p_data_d;
      d_sel_q   <= d_sel_d;
      p_valid_q <= p_valid_d;
      s2p_end_q <= s2p_end_d;
      err_q     <= err_d;
    end
  end

  assign p_data  = p_data_q;
  assign d_sel   = d_sel_q;
  assign p_valid = p_valid_q;
  assign s2p_end = s2p_end_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mch_dec_s2p_top.sv
// -----------------------------------------------------------------------------
// tb_mch_dec_s2p_top
// Self-checking bench for mch_dec_s2p_top. Frames are generated as Manchester
// waveforms from byte arrays; the expected byte stream of each frame is derived
// from the frame contents and the injected event (violation, reset, short
// idle) and compared with what a monitor collects from the outputs.
// -----------------------------------------------------------------------------
module tb_mch_dec_s2p_top;

  localparam int HALF   = 25;
  localparam int NBYTES = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxsdi;
  logic [7:0] p_data;
  logic [2:0] d_sel;
  logic       p_valid;
  logic       s2p_end;
  logic       err;

  mch_dec_s2p_top #(
    .HALF      (HALF),
    .NBYTES    (NBYTES),
    .IDLE_BITS (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rxsdi   (rxsdi),
    .p_data  (p_data),
    .d_sel   (d_sel),
    .p_valid (p_valid),
    .s2p_end (s2p_end),
    .err     (err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Output monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  logic [11:0] obs_q[$];
  int          err_cnt    = 0;
  int          end_cnt    = 0;
  int          proto_bad  = 0;
  logic        prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (p_valid) obs_q.push_back({s2p_end, d_sel, p_data});
      if (err)     err_cnt <= err_cnt + 1;
      if (s2p_end) end_cnt <= end_cnt + 1;
      if ((s2p_end && !p_valid) || (err && p_valid) ||
          (prev_pulse && (p_valid || s2p_end || err)))
        proto_bad <= proto_bad + 1;
      prev_pulse <= p_valid | s2p_end | err;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: expected delivered bytes per frame
  // ---------------------------------------------------------------------------
  logic [7:0]  frame [NBYTES];
  logic [11:0] exp_q[$];
  logic [7:0]  last_data = 8'h00;
  logic [2:0]  last_sel  = 3'd0;
  int          exp_err   = 0;
  int          exp_end   = 0;

  // viol: index of the violating data bit (-1 = none); cut: bytes delivered
  // before a reset (-1 = none); ignored: frame not armed, nothing delivered.
  task automatic model_frame(input int viol, input int cut, input bit ignored);
    int n;
    if (ignored) return;
    n = NBYTES;
    if (viol >= 0) n = viol / 8;
    if (cut >= 0)  n = cut;
    for (int b = 0; b < n; b++) begin
      exp_q.push_back({(b == NBYTES - 1) ? 1'b1 : 1'b0, 3'(b), frame[b]});
      last_data = frame[b];
      last_sel  = 3'(b);
    end
    if (viol >= 0)   exp_err++;
    if (n == NBYTES) exp_end++;
  endtask

  task automatic check_frame(input string tag);
    int n;
    check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d{end,sel,data}", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    check($sformatf("%s_err_total", tag), err_cnt, exp_err);
    check($sformatf("%s_end_total", tag), end_cnt, exp_end);
    check($sformatf("%s_pulse_rules", tag), proto_bad, 0);
    check($sformatf("%s_p_data_hold", tag), p_data, last_data);
    check($sformatf("%s_d_sel_hold", tag), d_sel, last_sel);
  endtask

  // ---------------------------------------------------------------------------
  // Line driver (changes rxsdi on the falling edge)
  // ---------------------------------------------------------------------------
  int   clk_in_frame = 0;
  int   rst_at       = -1;
  bit   aborted      = 1'b0;
  logic viol_lvl     = 1'b1;

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (!aborted) rxsdi = v;
      if (rst_at >= 0 && clk_in_frame == rst_at && !aborted) begin
        rxsdi   = 1'b1;
        rst     = 1'b1;
        aborted = 1'b1;
        #1;
        check("rst_mid_p_data", p_data, 8'h00);
        check("rst_mid_d_sel", d_sel, 3'd0);
        check("rst_mid_pulses", {p_valid, s2p_end, err}, 3'b000);
      end
      clk_in_frame++;
      @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic v, input int h);
    drive(v, h);
    drive(~v, h);
  endtask

  // h: half-cell length in clocks; viol: data bit index replaced by a flat
  // cell at level viol_lvl, after which the line returns high.
  task automatic send_frame(input int h, input int viol);
    int idx;
    clk_in_frame = 0;
    aborted      = 1'b0;
    send_bit(1'b0, h);
    for (int b = 0; b < NBYTES; b++) begin
      for (int k = 7; k >= 0; k--) begin
        idx = b * 8 + (7 - k);
        if (idx == viol) begin
          drive(viol_lvl, 2 * h);
          rxsdi = 1'b1;
          return;
        end
        send_bit(frame[b][k], h);
      end
    end
    rxsdi = 1'b1;
  endtask

  task automatic load_ref_frame();
    frame[0] = 8'h05; frame[1] = 8'hA5; frame[2] = 8'h3C; frame[3] = 8'hFF;
    frame[4] = 8'h00; frame[5] = 8'h81; frame[6] = 8'h7E;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int h, v;
    rst   = 1'b1;
    rxsdi = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_p_data", p_data, 8'h00);
    check("reset_d_sel", d_sel, 3'd0);
    check("reset_pulses", {p_valid, s2p_end, err}, 3'b000);
    rst = 1'b0;
    drive(1'b1, 200);

    // Clean reference frame
    load_ref_frame();
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("clean");

    // Flat high cell at byte 2 bit 4, then a clean frame
    viol_lvl = 1'b1;
    send_frame(HALF, 2 * 8 + 4);
    model_frame(2 * 8 + 4, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("violation");
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("after_violation");

    // Glitch: short low pulse leaves the decoder armed; frame follows after
    // only 30 high clocks, which would not re-qualify from idle.
    drive(1'b0, 5);
    drive(1'b1, 30);
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("glitch");

    // Drift: 48-clock cells, then 52-clock cells
    send_frame(24, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("drift48");
    send_frame(26, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("drift52");

    // Short idle: frame after only 60 high clocks is ignored
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 60);
    for (int b = 0; b < NBYTES; b++) frame[b] = 8'($urandom);
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b1);
    drive(1'b1, 150);
    check_frame("short_idle");
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("after_short_idle");

    // Reset during byte 3 (bit 4 of byte 3)
    load_ref_frame();
    rst_at = (1 + 3 * 8 + 4) * 2 * HALF;
    send_frame(HALF, -1);
    rst_at = -1;
    model_frame(-1, 3, 1'b0);
    last_data = 8'h00;
    last_sel  = 3'd0;
    rst = 1'b0;
    drive(1'b1, 60);
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b1);
    drive(1'b1, 150);
    check_frame("reset_mid_frame");
    send_frame(HALF, -1);
    model_frame(-1, -1, 1'b0);
    drive(1'b1, 150);
    check_frame("after_reset");

    // Randomized frames: random data, drift and optional violation
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < NBYTES; b++) frame[b] = 8'($urandom);
      h        = 24 + int'($urandom_range(0, 2));
      v        = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NBYTES * 8 - 1)) : -1;
      viol_lvl = 1'($urandom_range(0, 1));
      send_frame(h, v);
      model_frame(v, -1, 1'b0);
      drive(1'b1, 150);
      check_frame($sformatf("rand%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
